instruction_fetch: RTL

- Fetch stage directly downstream of `program_counter`. Each cycle it:
  - takes the current PC;
  - issues a synchronous read to instruction memory (1-cycle read latency);
  - buffers returned words in a 2-entry queue;
  - presents them to decode over a valid/ready handshake.
- Drives `program_counter.run` so the PC advances only when a fetch is issued or a jump is taken.
- Discards in-flight and buffered words on a flush.

---
 rtl/instruction_fetch.sv | 105 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: issues 1-cycle-latency instruction-memory reads from the current PC and
// buffers returned words in a 2-entry queue presented to decode over valid/ready.
module instruction_fetch #(
  parameter int unsigned PROGRAM_COUNTER_WIDTH = 16,
  parameter int unsigned INSTR_WIDTH           = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             flush,
  input  logic [PROGRAM_COUNTER_WIDTH-1:0] pc,
  output logic                             pc_run,
  output logic                             imem_en,
  output logic [PROGRAM_COUNTER_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]           imem_rdata,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [INSTR_WIDTH-1:0]           instr,
  output logic [PROGRAM_COUNTER_WIDTH-1:0] instr_pc
);

  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CREDIT_W = 3;
  localparam int unsigned DEPTH    = 2;

  logic [INSTR_WIDTH-1:0]           data_q [DEPTH];
  logic [INSTR_WIDTH-1:0]           data_d [DEPTH];
  logic [PROGRAM_COUNTER_WIDTH-1:0] tag_q  [DEPTH];
  logic [PROGRAM_COUNTER_WIDTH-1:0] tag_d  [DEPTH];
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             head_q, head_d;
  logic                             tail_q, tail_d;
  logic                             inflight_v_q, inflight_v_d;
  logic [PROGRAM_COUNTER_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic                             pop;
  logic                             push;
  logic                             issue;
  logic [CREDIT_W-1:0]              credit;

  // Credit counts buffered plus in-flight words, so a returning word always has a slot.
  always_comb begin
    instr_valid = ~rst & (count_q != '0);
    pop         = instr_valid & instr_ready;
    push        = inflight_v_q & ~flush & ~rst;
    credit      = CREDIT_W'(count_q) + CREDIT_W'(inflight_v_q) - CREDIT_W'(pop);
    issue       = ~rst & enable & ~flush & (credit < CREDIT_W'(2));
    imem_en     = issue;
    imem_addr   = pc;
    pc_run      = ~rst & (issue | flush);
    instr       = instr_valid ? data_q[head_q] : '0;
    instr_pc    = instr_valid ? tag_q[head_q]  : '0;
  end

  always_comb begin
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    inflight_v_d  = inflight_v_q;
    inflight_pc_d = inflight_pc_q;
    data_d        = data_q;
    tag_d         = tag_q;
    if (rst) begin
      count_d       = '0;
      head_d        = 1'b0;
      tail_d        = 1'b0;
      inflight_v_d  = 1'b0;
      inflight_pc_d = '0;
    end else if (flush) begin
      count_d      = '0;
      head_d       = 1'b0;
      tail_d       = 1'b0;
      inflight_v_d = 1'b0;
    end else begin
      if (push) begin
        data_d[tail_q] = imem_rdata;
        tag_d[tail_q]  = inflight_pc_q;
        tail_d         = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      inflight_v_d = issue;
      if (issue) begin
        inflight_pc_d = pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q       <= count_d;
    head_q        <= head_d;
    tail_q        <= tail_d;
    inflight_v_q  <= inflight_v_d;
    inflight_pc_q <= inflight_pc_d;
  end

  // Queue payload carries no reset; output gating hides it while empty.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule
